// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer slice.
package counter_seq_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        OP_RST  = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DN   = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

    function automatic logic is_step_op(input cmd_op_t op);
        return (op == OP_UP) || (op == OP_DN);
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Command handshake between a requester and the counter sequencer.
interface counter_seq_if
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    cmd_op_t          cmd_op;
    logic [WIDTH-1:0] cmd_val;

    modport master (output cmd_valid, output cmd_op, output cmd_val, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_val, output cmd_ready);
endinterface

// File: rtl/counter_seq_timer.sv
// WAIT-phase timeout counter: clear reloads zero, en steps, expire flags the last allowed cycle.
module counter_seq_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

    logic [TW-1:0] count_r;

    // Timer register: clear has priority over counting
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_r <= {TW{1'b0}};
        end else if (clear) begin
            count_r <= {TW{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry decode
    always_comb begin
        expire = (count_r == TW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a 4-bit counter. Optional COUNTER_SEQ_WRAP_CHECK_EN adds
// early abort when the counter wraps twice before reaching its target.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             reset,
    counter_seq_if.slave     cmd,
    input  logic [WIDTH-1:0] cnt,
    output logic             cnt_rst,
    output logic [WIDTH-1:0] load,
    output logic             load_en,
    output logic             chnge,
    output logic             cnt_en,
    output logic             done,
    output logic             err
);
    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] ISSUE = ST_ISSUE;
    localparam logic [2:0] WAIT  = ST_WAIT;
    localparam logic [2:0] DONE  = ST_DONE;
    localparam logic [2:0] ERR   = ST_ERR;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [2:0]       state_r;
    cmd_op_t          op_r;
    logic [WIDTH-1:0] tgt_r;
    logic             ready_r;
    logic             match_s;
    logic             step_s;
    logic             in_wait_s;
    logic             timer_clr_s;
    logic             timer_en_s;
    logic             expire_s;
    logic             wrap_abort_s;

    assign cmd.cmd_ready = ready_r;

    // Target compare and step enable; cnt_en stays combinational so the counter halts on target
    always_comb begin
        in_wait_s   = (state_r == WAIT);
        match_s     = (cnt == tgt_r);
        step_s      = is_step_op(op_r);
        cnt_en      = in_wait_s && step_s && !match_s;
        timer_clr_s = !in_wait_s;
        timer_en_s  = in_wait_s && !match_s;
    end

    counter_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (timer_clr_s),
        .en     (timer_en_s),
        .expire (expire_s)
    );

`ifdef COUNTER_SEQ_WRAP_CHECK_EN
    logic [WIDTH-1:0] cnt_prev_r;
    logic             wait_prev_r;
    logic [1:0]       wrap_cnt_r;
    logic             wrap_s;

    // Wrap detection needs one previous WAIT sample to be meaningful
    always_comb begin
        wrap_s = 1'b0;
        if (in_wait_s && wait_prev_r && step_s) begin
            if (op_r == OP_UP) begin
                wrap_s = (cnt_prev_r == ONES) && (cnt == ZERO);
            end else begin
                wrap_s = (cnt_prev_r == ZERO) && (cnt == ONES);
            end
        end else begin
            wrap_s = 1'b0;
        end
        wrap_abort_s = (wrap_cnt_r >= 2'd2);
    end

    // Wrap history, cleared outside WAIT
    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_prev_r  <= ZERO;
            wait_prev_r <= 1'b0;
            wrap_cnt_r  <= 2'd0;
        end else begin
            cnt_prev_r  <= cnt;
            wait_prev_r <= in_wait_s;
            if (!in_wait_s) begin
                wrap_cnt_r <= 2'd0;
            end else if (wrap_s && (wrap_cnt_r != 2'd3)) begin
                wrap_cnt_r <= wrap_cnt_r + 2'd1;
            end else begin
                wrap_cnt_r <= wrap_cnt_r;
            end
        end
    end
`else
    // Without the wrap check only the timer can abort a command
    always_comb begin
        wrap_abort_s = 1'b0;
    end
`endif

    // Main FSM; counter controls are registered and set on the accept edge so they show during ISSUE
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= OP_RST;
            tgt_r   <= ZERO;
            ready_r <= 1'b0;
            cnt_rst <= 1'b0;
            load    <= ZERO;
            load_en <= 1'b0;
            chnge   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (cmd.cmd_valid && ready_r) begin
                        op_r    <= cmd.cmd_op;
                        tgt_r   <= (cmd.cmd_op == OP_RST) ? ZERO : cmd.cmd_val;
                        ready_r <= 1'b0;
                        state_r <= ISSUE;
                        case (cmd.cmd_op)
                            OP_RST:  cnt_rst <= 1'b1;
                            OP_LOAD: begin
                                load    <= cmd.cmd_val;
                                load_en <= 1'b1;
                            end
                            OP_UP:   chnge <= 1'b1;
                            OP_DN:   chnge <= 1'b0;
                            default: cnt_rst <= 1'b0;
                        endcase
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_rst <= 1'b0;
                    load_en <= 1'b0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (match_s) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (wrap_abort_s || expire_s) begin
                        err     <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE, ERR: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed vector table, randomized commands against a latency model, mid-WAIT reset.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 64;

    logic             CLK = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cnt;
    logic             cnt_rst, load_en, chnge, cnt_en, done, err;
    logic [WIDTH-1:0] load;
    logic             freeze;

    counter_seq_if #(.WIDTH(WIDTH)) ifc ();

    counter_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .cmd     (ifc),
        .cnt     (cnt),
        .cnt_rst (cnt_rst),
        .load    (load),
        .load_en (load_en),
        .chnge   (chnge),
        .cnt_en  (cnt_en),
        .done    (done),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    // Simple 4-bit counter the sequencer drives; freeze makes it ignore cnt_en
    always_ff @(posedge CLK) begin
        if (reset)                 cnt <= 4'd0;
        else if (cnt_rst)          cnt <= 4'd0;
        else if (load_en)          cnt <= load;
        else if (cnt_en && !freeze) cnt <= chnge ? cnt + 4'd1 : cnt - 4'd1;
    end

    typedef struct {
        int lat; int en; int nd; int ne; int nld; int nrst; int ld_val; int ready_after; int fin_ok;
    } res_t;

    typedef struct {
        cmd_op_t op; logic [3:0] val; bit frz; int lat; int en; int er; int fin;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int exp_chnge;
    int ref_cnt;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: outcome of one command from the step distance modulo 16
    function automatic void ref_cmd(input cmd_op_t op, input int val, input int start, input bit frz,
                                    output int lat, output int en, output int er, output int fin);
        int steps;
        steps = 0;
        fin   = val;
        case (op)
            OP_RST:  fin = 0;
            OP_LOAD: fin = val;
            OP_UP:   steps = (val - start + 16) % 16;
            OP_DN:   steps = (start - val + 16) % 16;
            default: steps = 0;
        endcase
        if (frz && steps > 0) begin
            er = 1; lat = 2 + TIMEOUT; en = TIMEOUT; fin = start;
        end else begin
            er = 0; lat = 3 + steps; en = steps;
        end
    endfunction

    task automatic run_cmd(input cmd_op_t op, input logic [3:0] val, output res_t r);
        int k;
        bit fin;
        r.lat = 0; r.en = 0; r.nd = 0; r.ne = 0; r.nld = 0; r.nrst = 0;
        r.ld_val = -1; r.ready_after = 0; r.fin_ok = 0;
        k = 0;
        while (!ifc.cmd_ready && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (!ifc.cmd_ready) begin
            chk("ready_wait", 0, 1);
            return;
        end
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_val   = val;
        @(posedge CLK);
        @(negedge CLK);
        ifc.cmd_valid = 1'b0;
        k = 1;
        fin = 1'b0;
        while (!fin && k < 200) begin
            if (cnt_en)  r.en++;
            if (load_en) begin r.nld++; r.ld_val = int'(load); end
            if (cnt_rst) r.nrst++;
            if (done)    r.nd++;
            if (err)     r.ne++;
            if (done || err) begin
                r.lat = k;
                fin = 1'b1;
            end
            @(negedge CLK);
            k++;
        end
        if (!fin) begin
            chk("cmd_complete", 0, 1);
        end else begin
            r.nd += int'(done);
            r.ne += int'(err);
            r.ready_after = int'(ifc.cmd_ready);
            r.fin_ok = 1;
        end
    endtask

    task automatic check_cmd(input string tag, input cmd_op_t op, input logic [3:0] val, input res_t r,
                             input int lat, input int en, input int er, input int fin);
        if (op == OP_UP) exp_chnge = 1;
        if (op == OP_DN) exp_chnge = 0;
        chk({tag, ".latency"}, r.lat, lat);
        chk({tag, ".cnt_en_cycles"}, r.en, en);
        chk({tag, ".done_pulses"}, r.nd, (er != 0) ? 0 : 1);
        chk({tag, ".err_pulses"}, r.ne, er);
        chk({tag, ".final_cnt"}, int'(cnt), fin);
        chk({tag, ".load_en_pulses"}, r.nld, (op == OP_LOAD) ? 1 : 0);
        chk({tag, ".cnt_rst_pulses"}, r.nrst, (op == OP_RST) ? 1 : 0);
        chk({tag, ".chnge"}, int'(chnge), exp_chnge);
        chk({tag, ".ready_after"}, r.ready_after, 1);
        if (op == OP_LOAD) chk({tag, ".load_value"}, r.ld_val, int'(val));
        ref_cnt = fin;
    endtask

    initial begin
        res_t r;
        int lat, en, er, fin, acc;
        cmd_op_t op;
        logic [3:0] val;
        bit frz;

        tbl[0] = '{OP_RST,  4'd9,  1'b0, 3,  0,  0, 0};
        tbl[1] = '{OP_LOAD, 4'd3,  1'b0, 3,  0,  0, 3};
        tbl[2] = '{OP_UP,   4'd11, 1'b0, 11, 8,  0, 11};
        tbl[3] = '{OP_LOAD, 4'd1,  1'b0, 3,  0,  0, 1};
        tbl[4] = '{OP_DN,   4'd14, 1'b0, 6,  3,  0, 14};
        tbl[5] = '{OP_LOAD, 4'd14, 1'b0, 3,  0,  0, 14};
        tbl[6] = '{OP_UP,   4'd1,  1'b0, 6,  3,  0, 1};
        tbl[7] = '{OP_UP,   4'd1,  1'b0, 3,  0,  0, 1};
        tbl[8] = '{OP_UP,   4'd5,  1'b1, 66, 64, 1, 1};
        tbl[9] = '{OP_DN,   4'd0,  1'b0, 4,  1,  0, 0};

        reset = 1'b1;
        freeze = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = OP_RST;
        ifc.cmd_val = 4'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.cmd_ready", int'(ifc.cmd_ready), 0);
        chk("rst.chnge", int'(chnge), 1);
        chk("rst.outputs", int'({cnt_rst, load_en, cnt_en, done, err}), 0);
        chk("rst.load", int'(load), 0);
        reset = 1'b0;
        @(negedge CLK);
        chk("idle.cmd_ready", int'(ifc.cmd_ready), 1);
        chk("idle.chnge", int'(chnge), 1);
        chk("idle.outputs", int'({cnt_rst, load_en, cnt_en, done, err}), 0);
        exp_chnge = 1;
        ref_cnt = 0;

        for (int i = 0; i < 10; i++) begin
            freeze = tbl[i].frz;
            run_cmd(tbl[i].op, tbl[i].val, r);
            freeze = 1'b0;
            check_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].val, r,
                      tbl[i].lat, tbl[i].en, tbl[i].er, tbl[i].fin);
        end

        for (int i = 0; i < 40; i++) begin
            op  = cmd_op_t'(2'($urandom_range(0, 3)));
            val = 4'($urandom_range(0, 15));
            frz = is_step_op(op) && ($urandom_range(0, 7) == 0);
            ref_cmd(op, int'(val), ref_cnt, frz, lat, en, er, fin);
            freeze = frz;
            run_cmd(op, val, r);
            freeze = 1'b0;
            check_cmd($sformatf("rnd%0d", i), op, val, r, lat, en, er, fin);
        end

        // Reset in the middle of a long UP command
        run_cmd(OP_LOAD, 4'd2, r);
        check_cmd("midrst_load", OP_LOAD, 4'd2, r, 3, 0, 0, 2);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op = OP_UP;
        ifc.cmd_val = 4'd12;
        @(posedge CLK);
        @(negedge CLK);
        ifc.cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst.cnt_en_before", int'(cnt_en), 1);
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst.cnt_en", int'(cnt_en), 0);
        chk("midrst.done_err", int'({done, err}), 0);
        chk("midrst.cmd_ready_in_reset", int'(ifc.cmd_ready), 0);
        reset = 1'b0;
        @(negedge CLK);
        chk("midrst.cmd_ready_after", int'(ifc.cmd_ready), 1);
        chk("midrst.chnge", int'(chnge), 1);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            acc += int'(done) + int'(err) + int'(cnt_en);
            @(negedge CLK);
        end
        chk("midrst.quiet", acc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Hardware controller for the 4-bit counter interface. It accepts commands over a valid/ready handshake and drives the counter's control inputs: reset, parallel load, direction (chnge) and count enable. It reads back the counter value and reports completion or error for each command. It replaces the manual reset/load/direction stimulus sequences with a synthesizable driver in the counter subsystem.

Parameters:
WIDTH, 4, counter and command value width
TIMEOUT, 64, maximum WAIT cycles before a command aborts with err (must be >= 2**WIDTH + 2)

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  opcode, see package
cmd_val  input  WIDTH  load value / target value
cnt  input  WIDTH  current counter value
cnt_rst  output  1  counter synchronous reset pulse
load  output  WIDTH  parallel load value
load_en  output  1  load strobe
chnge  output  1  direction: 1 = up, 0 = down
cnt_en  output  1  counter step enable
done  output  1  one-cycle pulse, command completed
err  output  1  one-cycle pulse, command aborted

Behaviour:
- Reset (synchronous, active-high) -> IDLE. Output values in reset: cmd_ready=0, cnt_rst=0, load=0, load_en=0, chnge=1, cnt_en=0, done=0, err=0, tgt=0, timer=0. reset overrides any command in flight, including mid-WAIT; no done/err is emitted for an aborted command.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready the block latches op into op_r and cmd_val into tgt, then goes to ISSUE. cmd_ready=0 in every other state, so one command is outstanding at a time.
- ISSUE (exactly one cycle):
  - OP_RST: cnt_rst=1 and tgt is forced to 0.
  - OP_LOAD: load=tgt and load_en=1.
  - OP_UP / OP_DN: chnge is set to 1 / 0. chnge is a register and holds its value until the next UP or DN command.
  - Then go to WAIT with timer cleared.
- WAIT:
  - Each cycle, compare cnt against tgt.
  - cnt_en = (state==WAIT) && (op_r is UP or DN) && (cnt != tgt). cnt_en is combinational on cnt, so the counter stops on the target and never passes it.
  - On cnt==tgt -> DONE.
  - Otherwise timer increments. When timer == TIMEOUT-1 and there is no match -> ERR.
  - If cnt already equals tgt on WAIT entry, the block goes to DONE after one WAIT cycle and cnt_en stays 0.
- DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, then IDLE. done and err are never asserted together.
- Latency from accept to done: OP_RST and OP_LOAD take 3 cycles when the counter responds in one cycle (accept, ISSUE, WAIT match, DONE pulse). UP/DN take 3 + steps cycles.
- Wrap-around: UP from 14 to target 1 steps 14, 15, 0, 1 (3 steps). DN wraps 0 to 15. Arithmetic is modulo 2**WIDTH; the block makes no attempt to choose the shorter direction.
- load, chnge and tgt are held stable outside ISSUE. load_en and cnt_rst are single-cycle pulses.

Optional Feature:
COUNTER_SEQ_WRAP_CHECK_EN
- Defined: in WAIT for UP/DN, a 2-bit wrap counter increments on each observed wrap (cnt goes from all-ones to 0 on UP, or 0 to all-ones on DN). A second wrap before a match goes to ERR on the following cycle; this catches a counter running in the wrong direction faster than the timeout would.
- Undefined: no wrap logic is built; only TIMEOUT produces err.

Decomposition:
- Package counter_seq_pkg contains:
  - typedef enum logic [1:0] {OP_RST=0, OP_LOAD=1, OP_UP=2, OP_DN=3} cmd_op_t
  - typedef enum of the FSM states
  - localparam default WIDTH=4
- One sub-module, counter_seq_timer: a loadable timeout counter with clear, enable and expire outputs, parameterized by TIMEOUT.

Test Plan:
- Reset high for 2 cycles, then low -> cmd_ready=1, chnge=1, and all other outputs 0.
- OP_LOAD val=3, counter model loads next cycle -> load=3 with a 1-cycle load_en; done 3 cycles after accept; cnt_en never asserted.
- OP_UP val=11 from cnt=3 -> cnt_en high for exactly 8 cycles; the counter stops at 11; done pulses once.
- OP_DN val=14 from cnt=1 -> counter wraps to 15 then 14; done after 3 steps; no err.
- Counter model frozen, then OP_UP val=5 -> err after TIMEOUT WAIT cycles and no done. With COUNTER_SEQ_WRAP_CHECK_EN and the model counting down instead, err fires on the second wrap.
- Reset asserted mid-WAIT of OP_UP -> next cycle the block is in IDLE with cnt_en=0, no done/err, and cmd_ready=1 after reset deasserts.
